forward_hazard_unit: RTL

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/forward_hazard_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : forward_hazard_unit
//  Purpose  : Operand forwarding select and load-use stall control for an
//             in-order pipeline. The instruction in ID is compared against
//             the EX and MEM producers; the chosen forward source is
//             registered so it is valid when that instruction reaches EX.
//             A load in EX feeding an ID operand stalls for LOAD_LAT cycles.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             id_src           - NUM_SRC packed source register numbers
//             id_src_valid     - per-operand read flag
//             ex_dst/mem_dst   - producer destination registers
//             ex_regwrite/mem_regwrite - producer write enables
//             ex_memread       - EX instruction is a load
//             fwd_sel          - registered 2-bit select per operand
//                                (11 = MEM, 10 = WB, 00 = register file)
//             stall/flush_ex   - hold front end / bubble into EX
//             stall_cycles     - saturating count of stalled cycles
//  Revision : 1.0 - initial release
// ============================================================================
module forward_hazard_unit #(
    parameter int REG_AW      = 5,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_valid,
    input  logic [REG_AW-1:0]           ex_dst,
    input  logic [REG_AW-1:0]           mem_dst,
    input  logic                        ex_regwrite,
    input  logic                        mem_regwrite,
    input  logic                        ex_memread,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        stall,
    output logic                        flush_ex,
    output logic [15:0]                 stall_cycles
);

    // The first stall cycle is spent in IDLE, so HOLD covers LOAD_LAT-1
    // cycles: counter runs LOAD_LAT-2 down to 0 inclusive.
    localparam logic [3:0] c_CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_next;
    logic                   w_stall;
    logic                   w_hazard;
    logic                   w_ex_dst_ok;
    logic                   w_mem_dst_ok;
    logic [NUM_SRC-1:0]     w_match_ex;
    logic [NUM_SRC-1:0]     w_match_mem;
    logic [2*NUM_SRC-1:0]   w_fwd_next;
    logic [2*NUM_SRC-1:0]   r_fwd_sel;
    logic [15:0]            r_stall_cycles;

    // Register 0 is never a real producer when it is hardwired to zero.
    assign w_ex_dst_ok  = (ZERO_REG_EN == 0) || (|ex_dst);
    assign w_mem_dst_ok = (ZERO_REG_EN == 0) || (|mem_dst);

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            logic [REG_AW-1:0] w_src;
            assign w_src          = id_src[k*REG_AW +: REG_AW];
            assign w_match_ex[k]  = id_src_valid[k] & ex_regwrite &
                                    (w_src == ex_dst) & w_ex_dst_ok;
            assign w_match_mem[k] = id_src_valid[k] & mem_regwrite &
                                    (w_src == mem_dst) & w_mem_dst_ok;
            // EX holds the youngest producer, so it wins over MEM.
            assign w_fwd_next[2*k +: 2] = w_match_ex[k]  ? 2'b11 :
                                          w_match_mem[k] ? 2'b10 : 2'b00;
        end
    endgenerate

    assign w_hazard = ex_memread & (|w_match_ex);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_hazard;
                if (w_hazard && (LOAD_LAT > 1)) begin
                    w_state_next = HOLD;
                    w_cnt_next   = c_CNT_INIT;
                end
            end
            HOLD: begin
                // Hazard inputs are ignored while holding.
                w_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (reset) begin
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= 4'd0;
            r_fwd_sel      <= '0;
            r_stall_cycles <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // A stalled cycle pushes a bubble into EX, which reads nothing.
            r_fwd_sel <= w_stall ? '0 : w_fwd_next;
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign fwd_sel      = r_fwd_sel;
    assign stall        = w_stall;
    assign flush_ex     = w_stall;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
